// File: rtl/nios_mul_unit.sv
// Two-stage pipelined Nios II multiply unit (mul, mulxss, mulxsu, mulxuu).
// Stage 1 registers four half-width partial products; stage 2 combines them and selects the word.
module nios_mul_unit #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int H  = DATA_W / 2;
    localparam int W2 = 2 * DATA_W;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXSS = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXUU = 2'b11
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] p_ll;
        logic [DATA_W-1:0] p_lh;
        logic [DATA_W-1:0] p_hl;
        logic [DATA_W-1:0] p_hh;
        logic [DATA_W-1:0] corr;
    } s1_t;

    s1_t               s1, s1_nxt;
    logic              s1_valid, s2_valid;
    logic              s2_load, s1_adv, accept;
    logic              sa, sb;
    op_e               op_in;
    logic [DATA_W:0]   mid_sum;
    logic [W2-1:0]     prod;
    logic [DATA_W-1:0] result_nxt;

    assign s2_load   = ~s2_valid | out_ready;
    assign s1_adv    = s2_load | ~s1_valid;
    assign in_ready  = s1_adv & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;

    // Signed variants use the unsigned product and subtract a correction in stage 2:
    // a signed operand with its MSB set contributes -2^DATA_W * (other operand).
    always_comb begin
        op_in       = op_e'(in_op);
        sa          = (op_in == OP_MULXSS) || (op_in == OP_MULXSU);
        sb          = (op_in == OP_MULXSS);
        s1_nxt      = '0;
        s1_nxt.op   = op_in;
        s1_nxt.tag  = in_tag;
        s1_nxt.p_ll = DATA_W'(in_a[H-1:0])      * DATA_W'(in_b[H-1:0]);
        s1_nxt.p_lh = DATA_W'(in_a[H-1:0])      * DATA_W'(in_b[DATA_W-1:H]);
        s1_nxt.p_hl = DATA_W'(in_a[DATA_W-1:H]) * DATA_W'(in_b[H-1:0]);
        s1_nxt.p_hh = DATA_W'(in_a[DATA_W-1:H]) * DATA_W'(in_b[DATA_W-1:H]);
        s1_nxt.corr = ((sa && in_a[DATA_W-1]) ? in_b : '0)
                    + ((sb && in_b[DATA_W-1]) ? in_a : '0);
    end

    // Cross terms keep their carry so the middle sum cannot wrap.
    always_comb begin
        mid_sum = {1'b0, s1.p_lh} + {1'b0, s1.p_hl};
        prod    = {s1.p_hh, s1.p_ll} + (W2'(mid_sum) << H);
        if (s1.op == OP_MUL)
            result_nxt = prod[DATA_W-1:0];
        else
            result_nxt = prod[W2-1:DATA_W] - s1.corr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (s1_adv)
                s1_valid <= in_valid;
            if (accept)
                s1 <= s1_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            if (flush)
                s2_valid <= 1'b0;
            else if (s2_load)
                s2_valid <= s1_valid;
            if (s2_load && s1_valid && !flush) begin
                out_result <= result_nxt;
                out_tag    <= s1.tag;
            end
        end
    end

endmodule

// File: tb/tb_nios_mul_unit.sv
// Directed bench for nios_mul_unit: op results, latency, backpressure ordering, flush and reset.
`timescale 1ns/1ps
module tb_nios_mul_unit;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam logic [1:0] MUL = 2'b00, MULXSS = 2'b01, MULXSU = 2'b10, MULXUU = 2'b11;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_a, in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;

    int n_cmp = 0;
    int n_err = 0;

    nios_mul_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op into an empty pipe with out_ready high; result expected two cycles later.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        #1;
        chk({name, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        chk({name, "_lat1"}, out_valid, 0);
        tick();
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_result"}, out_result, exp);
        chk({name, "_tag"}, out_tag, tag);
        tick();
        chk({name, "_drain"}, out_valid, 0);
    endtask

    logic [1:0]  bp_op [4];
    logic [31:0] bp_a  [4];
    logic [31:0] bp_b  [4];
    logic [31:0] bp_exp[4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int idx, got, xfers;
        logic acc;

        reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        tick();

        run_op("mul_basic",   MUL,    32'h0001_0003, 32'h0002_0005, 5'd1,  32'h000B_000F);
        run_op("mulxuu_basic",MULXUU, 32'h0001_0003, 32'h0002_0005, 5'd2,  32'h0000_0002);
        run_op("mulxuu_ones", MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE);
        run_op("mul_ones",    MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0001);
        run_op("mulxss_m1x2", MULXSS, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5,  32'hFFFF_FFFF);
        run_op("mulxsu_2xff", MULXSU, 32'h0000_0002, 32'hFFFF_FFFF, 5'd6,  32'h0000_0001);
        run_op("mulxss_minsq",MULXSS, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000);
        run_op("mulxss_zero", MULXSS, 32'h0000_0000, 32'h8000_0000, 5'd8,  32'h0000_0000);
        run_op("mulxsu_zero", MULXSU, 32'hFFFF_FFFF, 32'h0000_0000, 5'd9,  32'h0000_0000);
        run_op("mulxsu_m1xff",MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF);

        // Backpressure: four back-to-back ops, consumer stalled for the first four cycles.
        bp_op  = '{MUL, MULXUU, MULXSS, MUL};
        bp_a   = '{32'h0000_0003, 32'h0001_0003, 32'hFFFF_FFFF, 32'h0001_0000};
        bp_b   = '{32'h0000_0005, 32'h0002_0005, 32'h0000_0002, 32'h0001_0000};
        bp_exp = '{32'h0000_000F, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 16 && got < 4; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (idx < 4);
            if (idx < 4) begin
                in_op  = bp_op[idx];
                in_a   = bp_a[idx];
                in_b   = bp_b[idx];
                in_tag = 5'(idx + 1);
            end
            #1;
            if (cyc == 1) chk("bp_in_ready_second", in_ready, 1);
            if (cyc == 2) chk("bp_in_ready_drop", in_ready, 0);
            if (cyc == 3) chk("bp_in_ready_hold", in_ready, 0);
            if (cyc >= 4) chk("bp_no_gap", out_valid, 1);
            if (out_valid && out_ready) begin
                chk("bp_result", out_result, bp_exp[got]);
                chk("bp_tag", out_tag, 64'(got + 1));
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_count", got, 4);
        chk("bp_drained", out_valid, 0);

        // Flush: two ops held by backpressure, then flushed with a third offered alongside.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = MUL; in_a = 32'd6; in_b = 32'd7; in_tag = 5'd20;
        tick();
        in_tag = 5'd21; in_a = 32'd8;
        tick();
        flush = 1'b1; in_tag = 5'd22; in_a = 32'd9;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", out_valid, 0);
        xfers = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) xfers++;
            tick();
        end
        chk("flush_no_result", xfers, 0);
        run_op("after_flush", MUL, 32'h0000_0009, 32'h0000_000B, 5'd23, 32'h0000_0063);

        // Reset pulse with two ops in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = MUL; in_a = 32'h0001_0003; in_b = 32'h0002_0005; in_tag = 5'd17;
        tick();
        in_tag = 5'd18;
        tick();
        in_valid = 1'b0;
        chk("rst_mid_pre_valid", out_valid, 1);
        chk("rst_mid_pre_tag", out_tag, 17);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_result", out_result, 0);
        chk("rst_mid_out_tag", out_tag, 0);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_mid_in_ready", in_ready, 1);
        xfers = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) xfers++;
            tick();
        end
        chk("rst_mid_no_stale", xfers, 0);
        run_op("after_reset", MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nios_mul_unit.md
Name: nios_mul_unit

Overview:
- Parametrised, pipelined integer multiply unit for the Nios II-class CPU execute/memory stages.
- Successor to the fixed 3-partial-product, low-word-only multiply cell; adds:
  - a fourth partial product and the full 2*DATA_W product
  - the four Nios II multiply ops (mul, mulxss, mulxsu, mulxuu)
  - valid/ready handshake with backpressure, flush and tag pass-through
- Two register stages: partial products, then combine/select.

Parameters:
- DATA_W, 32, operand/result width; even, >= 8; H = DATA_W/2.
- TAG_W, 5, width of the opaque tag carried with each op (e.g. destination register index).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the offered operation this cycle.
- in_op  in  2  00=MUL (low word), 01=MULXSS, 10=MULXSU, 11=MULXUU (high word).
- in_a  in  DATA_W  operand A (src1).
- in_b  in  DATA_W  operand B (src2).
- in_tag  in  TAG_W  tag, returned unchanged with the result.
- flush  in  1  kill all in-flight operations.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_result  out  DATA_W  selected result word.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (async assert, sync release):
  - s1_valid = s2_valid = 0; out_valid = 0; out_result = 0; out_tag = 0; in_ready = 1 after reset.
  - Stage data registers clear to 0.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - in_op/in_a/in_b/in_tag are sampled only on an accepted transfer.
- Stage 1, on accept, registers:
  - p_ll = a[H-1:0]*b[H-1:0]; p_lh = a[H-1:0]*b[DATA_W-1:H]; p_hl = a[DATA_W-1:H]*b[H-1:0]; p_hh = a[DATA_W-1:H]*b[DATA_W-1:H]. All four are unsigned, 2H bits wide.
  - corr (DATA_W bits, mod 2^DATA_W): (sa & a[MSB] ? b : 0) + (sb & b[MSB] ? a : 0).
    - MULXSS: sa=1, sb=1. MULXSU: sa=1, sb=0. MULXUU and MUL: sa=0, sb=0.
  - op and tag are carried alongside.
- Stage 2 (output register) computes:
  - P = p_ll + ((p_lh + p_hl) << H) + (p_hh << DATA_W), with width 2*DATA_W; the p_lh + p_hl carry must be kept (width 2H+1).
  - out_result = P[DATA_W-1:0] for MUL; otherwise P[2*DATA_W-1:DATA_W] - corr (mod 2^DATA_W).
- Latency and throughput:
  - Op accepted at edge N gives out_valid=1 after edge N+2 when there is no stall.
  - Throughput is 1 op/cycle.
- Flow control:
  - s2 loads when ~s2_valid | out_ready. s1 advances when s2 loads or ~s1_valid.
  - in_ready = ~s1_valid | s1 advances (combinational on out_ready; no combinational path from in_valid).
  - A stalled stage holds data and tag unchanged. Results leave in issue order; none are dropped or duplicated.
- Flush:
  - Synchronous; clears s1_valid and s2_valid at the next edge. out_valid = 0 the following cycle.
  - in_ready is forced 0 during the flush cycle, so an op offered alongside flush is not accepted.
  - out_result/out_tag may hold stale values while out_valid=0.
- Asserting reset_n low mid-operation discards all in-flight ops immediately; outputs return to reset values.
- Boundary values:
  - Operand 0 yields 0 for all ops.
  - Most-negative × most-negative with MULXSS gives high word 0x4000_0000 (DATA_W=32).
  - No overflow flag; MUL result wraps modulo 2^DATA_W.

Test Plan:
- MUL, a=0x0001_0003, b=0x0002_0005 -> out_result 0x000B_000F two cycles after accept; same operands with MULXUU -> 0x0000_0002.
- MULXUU, a=b=0xFFFF_FFFF -> 0xFFFF_FFFE; MUL with the same operands -> 0x0000_0001.
- MULXSS, a=0xFFFF_FFFF, b=0x0000_0002 -> 0xFFFF_FFFF. MULXSU, a=0x0000_0002, b=0xFFFF_FFFF -> 0x0000_0001. MULXSS, a=b=0x8000_0000 -> 0x4000_0000.
- Back-to-back issue of tags 1,2,3,4 with out_ready=0 for 4 cycles:
  - in_ready drops after 2 ops are accepted.
  - With out_ready=1, results and tags emerge 1,2,3,4 in order with correct values and no gaps.
- flush asserted one cycle after issuing 2 ops -> out_valid stays 0, neither result appears; an op offered in the flush cycle is not accepted, and a later op completes normally.
- reset_n pulsed low for 1 cycle while 2 ops are in flight -> out_valid=0 and out_result=0 immediately; in_ready=1 after release; no stale result ever emitted.
